// File: rtl/timer_array.sv
// timer_array: multi-channel timer/counter with one-shot, auto-reload, PWM and free-run-up modes
// Each channel counts ticks derived from its own asynchronous divided-clock source.
module timer_array #(
    parameter int CH = 4,
    parameter int W  = 32,
    parameter int AW = $clog2(CH) + 2
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic [CH-1:0] src,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [CH-1:0] cnt_out,
    output logic          irq
);

    typedef enum logic [1:0] {ONE_SHOT, AUTO_RELOAD, PWM, FREE_RUN} mode_e;

    localparam logic [W-1:0] ONE = W'(1);

    logic [CH-1:0] s1_q, s2_q, s3_q, tick_q, arm_q;
    logic          live_q;
    logic [CH-1:0] en_q, en_d, ie_q, ie_d, done_q, done_d, out_q, out_d;
    logic [CH-1:0] set_v, tog_v;
    mode_e         mode_q [CH];
    mode_e         mode_d [CH];
    logic [W-1:0]  load_q [CH];
    logic [W-1:0]  load_d [CH];
    logic [W-1:0]  cmp_q  [CH];
    logic [W-1:0]  cmp_d  [CH];
    logic [W-1:0]  cnt_q  [CH];
    logic [W-1:0]  cnt_d  [CH];
    logic [31:0]   rdata_q, rdata_d;
    logic [AW-1:0] ch_idx;

    assign ch_idx  = addr >> 2;
    assign rdata   = rdata_q;
    assign cnt_out = out_q;
    assign irq     = |(done_q & ie_q);

    always_comb begin
        set_v = '0;
        tog_v = '0;
        en_d  = en_q;
        ie_d  = ie_q;
        for (int c = 0; c < CH; c++) begin
            mode_d[c] = mode_q[c];
            load_d[c] = (we && ch_idx == AW'(c) && addr[1:0] == 2'd1) ? wdata[W-1:0] : load_q[c];
            cmp_d[c]  = (we && ch_idx == AW'(c) && addr[1:0] == 2'd2) ? wdata[W-1:0] : cmp_q[c];
            cnt_d[c]  = cnt_q[c];
            // Reloads use load_d so a same-cycle LOAD write takes effect immediately
            if (tick_q[c] && en_q[c]) begin
                case (mode_q[c])
                    ONE_SHOT: begin
                        cnt_d[c] = (cnt_q[c] > ONE) ? cnt_q[c] - ONE : '0;
                        if (cnt_q[c] <= ONE) begin
                            set_v[c] = 1'b1;
                            en_d[c]  = 1'b0;
                        end
                    end
                    AUTO_RELOAD: begin
                        cnt_d[c] = (cnt_q[c] > ONE) ? cnt_q[c] - ONE : load_d[c];
                        set_v[c] = cnt_q[c] <= ONE;
                        tog_v[c] = cnt_q[c] <= ONE;
                    end
                    PWM: begin
                        cnt_d[c] = (cnt_q[c] == '0) ? load_d[c] : cnt_q[c] - ONE;
                        set_v[c] = cnt_q[c] == '0;
                    end
                    FREE_RUN: begin
                        cnt_d[c] = cnt_q[c] + ONE;
                        set_v[c] = &cnt_q[c];
                        tog_v[c] = &cnt_q[c];
                    end
                endcase
            end
            if (we && ch_idx == AW'(c) && addr[1:0] == 2'd0) begin
                en_d[c]   = wdata[0];
                mode_d[c] = mode_e'(wdata[2:1]);
                ie_d[c]   = wdata[3];
            end
            if (we && ch_idx == AW'(c) && addr[1:0] == 2'd1 && !en_q[c])
                cnt_d[c] = wdata[W-1:0];
            done_d[c] = set_v[c] | (done_q[c] & ~(we && ch_idx == AW'(c) && addr[1:0] == 2'd3));
            out_d[c]  = (mode_d[c] == ONE_SHOT) ? (en_d[c] && cnt_d[c] != '0) :
                        (mode_d[c] == PWM)      ? (cnt_d[c] < cmp_d[c]) :
                                                  (out_q[c] ^ tog_v[c]);
        end
    end

    always_comb begin
        rdata_d = '0;
        for (int c = 0; c < CH; c++)
            if (ch_idx == AW'(c))
                rdata_d = (addr[1:0] == 2'd0) ? {28'b0, ie_q[c], mode_q[c], en_q[c]} :
                          (addr[1:0] == 2'd1) ? 32'(load_q[c]) :
                          (addr[1:0] == 2'd2) ? 32'(cmp_q[c])  : 32'(cnt_q[c]);
    end

    // arm_q needs a genuine low on src after reset, so a level held across release never ticks
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            tick_q  <= '0;
            arm_q   <= '0;
            live_q  <= 1'b0;
            en_q    <= '0;
            ie_q    <= '0;
            done_q  <= '0;
            out_q   <= '0;
            rdata_q <= '0;
            for (int c = 0; c < CH; c++) begin
                mode_q[c] <= ONE_SHOT;
                load_q[c] <= '0;
                cmp_q[c]  <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            s1_q    <= src;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            tick_q  <= s2_q & ~s3_q & arm_q;
            arm_q   <= arm_q | ({CH{live_q}} & ~s1_q);
            live_q  <= 1'b1;
            en_q    <= en_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            out_q   <= out_d;
            rdata_q <= rdata_d;
            for (int c = 0; c < CH; c++) begin
                mode_q[c] <= mode_d[c];
                load_q[c] <= load_d[c];
                cmp_q[c]  <= cmp_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
        end
    end

endmodule
